// File: rtl/fp24_pkg.sv
// Shared fp24 definitions: format widths, bias, the packed word layout and
// the divider FSM state encoding.
package fp24_pkg;

  localparam int unsigned FP24_W        = 24;
  localparam int unsigned FP24_EXP_W    = 6;
  localparam int unsigned FP24_FRAC_W   = 17;
  localparam int unsigned FP24_EXP_BIAS = 31;
  localparam int unsigned FP24_EXP_MAX  = 63;

  // Divider internals: mantissa with hidden bit, remainder, quotient bits.
  localparam int unsigned FP24_MANT_W = FP24_FRAC_W + 1;
  localparam int unsigned FP24_REM_W  = FP24_FRAC_W + 2;
  localparam int unsigned FP24_QQ_W   = FP24_FRAC_W + 3;

  typedef struct packed {
    logic                   sign;
    logic [FP24_EXP_W-1:0]  exp;
    logic [FP24_FRAC_W-1:0] frac;
  } fp24_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/fp24_div_seq_if.sv
// Operand/result handshake bundle for fp24_div_seq.
//   in_valid/in_ready/a/b    : operand channel (producer -> divider)
//   out_valid/out_ready/q/flags : result channel (divider -> consumer), flags={ovf,unf}
interface fp24_div_seq_if;
  import fp24_pkg::*;

  logic       in_valid;
  logic       in_ready;
  fp24_t      a;
  fp24_t      b;
  logic       out_valid;
  logic       out_ready;
  fp24_t      q;
  logic [1:0] flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, flags
  );
endinterface

// File: rtl/fp24_div_mant.sv
// Restoring mantissa divider: one quotient bit per clock for FP24_QQ_W clocks.
//   clk, rst_n : clock, async active-low reset
//   start_i    : load remainder with ma_i and restart the iteration count
//   ma_i       : dividend mantissa {1,frac}, sampled on start_i
//   mb_i       : divisor mantissa {1,frac}, must stay stable while iterating
//   done_c_o   : high during the final iteration cycle (combinational)
//   qq_o       : quotient, qq_o[MSB] is the integer bit
module fp24_div_mant
  import fp24_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [FP24_MANT_W-1:0] ma_i,
  input  logic [FP24_MANT_W-1:0] mb_i,
  output logic                   done_c_o,
  output logic [FP24_QQ_W-1:0]   qq_o
);

  localparam int unsigned ITER  = FP24_QQ_W;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  logic [FP24_REM_W-1:0] r_q;
  logic [FP24_QQ_W-1:0]  qq_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;

  logic                  qbit_c;
  logic [FP24_REM_W-1:0] r_sub_c;

  // Trial subtract; the restored remainder is always below mb, so the shift never loses a bit.
  always_comb begin
    qbit_c  = (r_q >= FP24_REM_W'(mb_i));
    r_sub_c = qbit_c ? (r_q - FP24_REM_W'(mb_i)) : r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      qq_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      r_q    <= FP24_REM_W'(ma_i);
      qq_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      r_q   <= {r_sub_c[FP24_REM_W-2:0], 1'b0};
      qq_q  <= {qq_q[FP24_QQ_W-2:0], qbit_c};
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(ITER - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_c_o = busy_q && (cnt_q == CNT_W'(ITER - 1));
  assign qq_o     = qq_q;

endmodule

// File: rtl/fp24_div_seq.sv
// Sequential fp24 divider q = a / b with valid/ready handshakes on both sides.
//   clk, rst_n : clock, async active-low reset (aborts any operation in flight)
//   bus        : fp24_div_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/q/flags)
// Result appears 21 clocks after the input handshake; flags = {ovf, unf}.
// Build option: define FP24_DIV_ROUND_EN for round-half-up on the guard bit;
// otherwise the quotient is truncated.
module fp24_div_seq
  import fp24_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fp24_div_seq_if.slave  bus
);

  localparam int unsigned EW = 8;

  div_state_t             state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  fp24_t                  q_q;
  logic [1:0]             flags_q;
  logic                   sign_q;
  logic [FP24_EXP_W-1:0]  ea_q;
  logic [FP24_EXP_W-1:0]  eb_q;
  logic [FP24_MANT_W-1:0] mb_q;

  logic                   accept_c;
  logic                   mant_done_c;
  logic [FP24_QQ_W-1:0]   qq_c;

  logic signed [EW-1:0]   e_base_c;
  logic signed [EW-1:0]   e_norm_c;
  logic signed [EW-1:0]   e_rnd_c;
  logic [FP24_FRAC_W-1:0] frac_c;
  logic [FP24_FRAC_W-1:0] frac_rnd_c;
  logic                   guard_c;
  logic                   ovf_c;
  logic                   unf_c;
  fp24_t                  q_c;

  assign accept_c = (state_q == IDLE) && bus.in_valid && in_ready_q;

  fp24_div_mant u_mant (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept_c),
    .ma_i     ({1'b1, bus.a.frac}),
    .mb_i     (mb_q),
    .done_c_o (mant_done_c),
    .qq_o     (qq_c)
  );

  // Normalise on the integer bit, then round (optional) and saturate the exponent.
  always_comb begin
    e_base_c = $signed(EW'(ea_q)) - $signed(EW'(eb_q)) + $signed(EW'(FP24_EXP_BIAS));
    if (qq_c[FP24_QQ_W-1]) begin
      frac_c   = qq_c[FP24_QQ_W-2:2];
      guard_c  = qq_c[1];
      e_norm_c = e_base_c;
    end else begin
      frac_c   = qq_c[FP24_QQ_W-3:1];
      guard_c  = qq_c[0];
      e_norm_c = e_base_c - $signed(EW'(1));
    end

`ifdef FP24_DIV_ROUND_EN
    // An all-ones fraction wraps to zero; the carry moves into the exponent.
    frac_rnd_c = frac_c + FP24_FRAC_W'(guard_c);
    e_rnd_c    = (&frac_c && guard_c) ? (e_norm_c + $signed(EW'(1))) : e_norm_c;
`else
    frac_rnd_c = frac_c;
    e_rnd_c    = e_norm_c;
`endif

    ovf_c = e_rnd_c > $signed(EW'(FP24_EXP_MAX));
    unf_c = e_rnd_c < $signed(EW'(0));

    q_c.sign = sign_q;
    if (ovf_c) begin
      q_c.exp  = '1;
      q_c.frac = '1;
    end else if (unf_c) begin
      q_c.exp  = '0;
      q_c.frac = '0;
    end else begin
      q_c.exp  = e_rnd_c[FP24_EXP_W-1:0];
      q_c.frac = frac_rnd_c;
    end
  end

  // Guard is only consumed by the rounding build.
  logic unused_guard_c;
  assign unused_guard_c = guard_c;

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      flags_q     <= '0;
      sign_q      <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      mb_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            sign_q     <= bus.a.sign ^ bus.b.sign;
            ea_q       <= bus.a.exp;
            eb_q       <= bus.b.exp;
            mb_q       <= {1'b1, bus.b.frac};
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (mant_done_c) begin
            state_q <= NORM;
          end
        end
        NORM: begin
          q_q         <= q_c;
          flags_q     <= {ovf_c, unf_c};
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.flags     = flags_q;

endmodule
